// File: rtl/jtkiwi_pkg.sv
// Shared types for the jtkiwi ROM caches: fetch FSM encoding, default line count
// and a saturating debug-counter helper.
package jtkiwi_pkg;

  localparam int unsigned ENTRIES_DEF = 4;
  localparam int unsigned DW          = 32;
  localparam int unsigned CNTW        = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_FILL = 2'd2
  } state_e;

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (v == {CNTW{1'b1}}) ? v : v + CNTW'(1);
  endfunction

endpackage

// File: rtl/jtkiwi_romcache_tags.sv
// Tag/valid store for the ROM cache: parallel tag compare with the lowest
// matching index winning.
module jtkiwi_romcache_tags
  import jtkiwi_pkg::*;
#(
  parameter  int unsigned AW      = 18,
  parameter  int unsigned ENTRIES = ENTRIES_DEF,
  localparam int unsigned IW      = $clog2(ENTRIES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic [AW-1:0] addr_i,
  input  logic          wr_en_i,
  input  logic [IW-1:0] wr_idx_i,
  input  logic [AW-1:0] wr_tag_i,
  output logic          hit,
  output logic [IW-1:0] hit_idx
);

  logic [ENTRIES-1:0] valid_q;
  logic [AW-1:0]      tag_q [ENTRIES];
  logic [ENTRIES-1:0] match_c;

  always_comb begin
    match_c = '0;
    for (int i = 0; i < int'(ENTRIES); i++) begin
      match_c[i] = valid_q[i] && (tag_q[i] == addr_i);
    end
  end

  // First match scanning upwards, so the lowest index has priority.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < int'(ENTRIES); i++) begin
      if (match_c[i] && !hit) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        tag_q[i] <= '0;
      end
    end else if (clr_i) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
      tag_q[wr_idx_i]   <= wr_tag_i;
    end
  end

endmodule

// File: rtl/jtkiwi_romcache.sv
// Fully-associative read cache between a graphics ROM request port and one
// SDRAM read slot; hits answer in one cycle, misses are fetched one at a time.
module jtkiwi_romcache
  import jtkiwi_pkg::*;
#(
  parameter int unsigned AW      = 18,
  parameter int unsigned ENTRIES = ENTRIES_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic [AW-1:0]   gfx_addr,
  input  logic            gfx_cs,
  output logic [DW-1:0]   gfx_data,
  output logic            gfx_ok,
  output logic [AW-1:0]   sdram_addr,
  output logic            sdram_cs,
  input  logic [DW-1:0]   sdram_data,
  input  logic            sdram_ok,
  output logic [CNTW-1:0] hits,
  output logic [CNTW-1:0] misses
);

  localparam int unsigned IW = $clog2(ENTRIES);

  state_e          state_q, state_d;
  logic            first_q, first_d;
  logic            flushed_q, flushed_d;
  logic [AW-1:0]   sdram_addr_q, sdram_addr_d;
  logic            sdram_cs_q, sdram_cs_d;
  logic [DW-1:0]   fill_q, fill_d;
  logic [DW-1:0]   gfx_data_q, gfx_data_d;
  logic            gfx_ok_q, gfx_ok_d;
  logic [CNTW-1:0] hits_q, hits_d;
  logic [CNTW-1:0] misses_q, misses_d;
  logic [IW-1:0]   victim_q, victim_d;
  logic [DW-1:0]   data_q [ENTRIES];
  logic            wr_en_c;
  logic            hit_c;
  logic [IW-1:0]   hit_idx_c;

  jtkiwi_romcache_tags #(
    .AW      (AW),
    .ENTRIES (ENTRIES)
  ) u_tags (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (flush),
    .addr_i   (gfx_addr),
    .wr_en_i  (wr_en_c),
    .wr_idx_i (victim_q),
    .wr_tag_i (sdram_addr_q),
    .hit      (hit_c),
    .hit_idx  (hit_idx_c)
  );

  always_comb begin
    state_d      = state_q;
    first_d      = 1'b0;
    flushed_d    = flushed_q | flush;
    sdram_addr_d = sdram_addr_q;
    sdram_cs_d   = sdram_cs_q;
    fill_d       = fill_q;
    gfx_data_d   = gfx_data_q;
    gfx_ok_d     = 1'b0;
    hits_d       = hits_q;
    misses_d     = misses_q;
    victim_d     = victim_q;
    wr_en_c      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (gfx_cs && !flush) begin
          if (hit_c) begin
            gfx_data_d = data_q[hit_idx_c];
            gfx_ok_d   = 1'b1;
            hits_d     = sat_inc(hits_q);
          end else begin
            sdram_addr_d = gfx_addr;
            sdram_cs_d   = 1'b1;
            misses_d     = sat_inc(misses_q);
            flushed_d    = 1'b0;
            first_d      = 1'b1;
            state_d      = ST_WAIT;
          end
        end
      end
      // The first WAIT cycle may still see ok from the previous slot user.
      ST_WAIT: begin
        if (sdram_ok && !first_q) begin
          fill_d     = sdram_data;
          sdram_cs_d = 1'b0;
          state_d    = ST_FILL;
        end
      end
      // A flush during the fetch means the word may come from the old bank.
      ST_FILL: begin
        wr_en_c = !(flush || flushed_q);
        if (wr_en_c) begin
          victim_d = victim_q + IW'(1);
        end
        if (gfx_cs && wr_en_c && (gfx_addr == sdram_addr_q)) begin
          gfx_data_d = fill_q;
          gfx_ok_d   = 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (flush) begin
      victim_d = '0;
      hits_d   = '0;
      misses_d = '0;
      gfx_ok_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      first_q      <= 1'b0;
      flushed_q    <= 1'b0;
      sdram_addr_q <= '0;
      sdram_cs_q   <= 1'b0;
      fill_q       <= '0;
      gfx_data_q   <= '0;
      gfx_ok_q     <= 1'b0;
      hits_q       <= '0;
      misses_q     <= '0;
      victim_q     <= '0;
    end else begin
      state_q      <= state_d;
      first_q      <= first_d;
      flushed_q    <= flushed_d;
      sdram_addr_q <= sdram_addr_d;
      sdram_cs_q   <= sdram_cs_d;
      fill_q       <= fill_d;
      gfx_data_q   <= gfx_data_d;
      gfx_ok_q     <= gfx_ok_d;
      hits_q       <= hits_d;
      misses_q     <= misses_d;
      victim_q     <= victim_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      data_q[victim_q] <= fill_q;
    end
  end

  assign gfx_data   = gfx_data_q;
  assign gfx_ok     = gfx_ok_q;
  assign sdram_addr = sdram_addr_q;
  assign sdram_cs   = sdram_cs_q;
  assign hits       = hits_q;
  assign misses     = misses_q;

endmodule

// File: tb/tb_jtkiwi_romcache.sv
// Self-checking bench for jtkiwi_romcache against an oldest-first replacement
// cache model with a scripted SDRAM slot.
module tb_jtkiwi_romcache;

  localparam int unsigned AW      = 18;
  localparam int unsigned ENTRIES = 4;
  localparam int K_NONE = 0, K_HIT = 1, K_MISS = 2, K_BAD = 3;

  logic          clk, rst_n, flush, gfx_cs, gfx_ok, sdram_cs, sdram_ok;
  logic [AW-1:0] gfx_addr, sdram_addr;
  logic [31:0]   gfx_data, sdram_data;
  logic [15:0]   hits, misses;

  int n_chk  = 0;
  int n_fail = 0;

  logic [AW-1:0] mdl_q[$];
  logic [31:0]   mdl_data [int];
  int            mdl_hits, mdl_misses;

  typedef struct {
    bit            got;
    int            ok_cyc;
    logic [31:0]   data;
    bit            cs1;
    bit            cs_seen;
    logic [AW-1:0] cs_addr;
    bit            addr_moved;
    int            m_cyc;
  } obs_t;

  jtkiwi_romcache #(.AW(AW), .ENTRIES(ENTRIES)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .gfx_addr   (gfx_addr),
    .gfx_cs     (gfx_cs),
    .gfx_data   (gfx_data),
    .gfx_ok     (gfx_ok),
    .sdram_addr (sdram_addr),
    .sdram_cs   (sdram_cs),
    .sdram_data (sdram_data),
    .sdram_ok   (sdram_ok),
    .hits       (hits),
    .misses     (misses)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [31:0] sd_word(input logic [AW-1:0] a);
    return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic void mdl_flush();
    mdl_q.delete();
    mdl_hits   = 0;
    mdl_misses = 0;
  endfunction

  // Cache of ENTRIES lines evicting the oldest fill; returns 1 on hit.
  function automatic bit mdl_access(input logic [AW-1:0] a, input logic [31:0] d);
    foreach (mdl_q[i]) begin
      if (mdl_q[i] == a) begin
        if (mdl_hits < 65535) mdl_hits++;
        return 1'b1;
      end
    end
    if (mdl_misses < 65535) mdl_misses++;
    if (mdl_q.size() == int'(ENTRIES)) void'(mdl_q.pop_front());
    mdl_q.push_back(a);
    mdl_data[int'(a)] = d;
    return 1'b0;
  endfunction

  function automatic int obs_kind(input obs_t o, input logic [AW-1:0] a);
    if (!o.got) return K_NONE;
    if (!o.cs_seen && o.ok_cyc == 1) return K_HIT;
    if (o.cs1 && o.cs_addr == a && !o.addr_moved && o.ok_cyc == o.m_cyc + 2) return K_MISS;
    return K_BAD;
  endfunction

  // Present a request and play the SDRAM slot: ok (data d) when sdram_cs has
  // been high for dly+1 cycles; with stale set, a bogus ok in its first cycle.
  task automatic run_req(input logic [AW-1:0] a, input logic [31:0] d, input int dly,
                         input bit stale, output obs_t o);
    int age;
    o.got = 0; o.ok_cyc = 0; o.data = '0; o.cs1 = 0; o.cs_seen = 0;
    o.cs_addr = '0; o.addr_moved = 0; o.m_cyc = -10;
    age = 0;
    gfx_addr = a;
    gfx_cs   = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (c == 1) o.cs1 = sdram_cs;
      if (gfx_ok) begin
        o.got = 1; o.ok_cyc = c; o.data = gfx_data;
        break;
      end
      if (sdram_cs) begin
        if (!o.cs_seen) begin
          o.cs_seen = 1; o.cs_addr = sdram_addr;
        end else if (sdram_addr !== o.cs_addr) begin
          o.addr_moved = 1;
        end
        age++;
        if (age == 1 && stale) begin
          sdram_ok = 1'b1; sdram_data = ~d;
        end else if (age == dly + 1) begin
          sdram_ok = 1'b1; sdram_data = d; o.m_cyc = c;
        end else begin
          sdram_ok = 1'b0; sdram_data = '0;
        end
      end else begin
        sdram_ok = 1'b0;
      end
    end
    gfx_cs   = 1'b0;
    sdram_ok = 1'b0;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      n_chk++;
      if (gfx_ok !== 1'b0 || sdram_cs !== 1'b0) begin
        n_fail++; $display("FAIL reset_ctl[%0d]: gfx_ok=%b sdram_cs=%b, want 0 0", k, gfx_ok, sdram_cs);
      end
      n_chk++;
      if (gfx_data !== 32'h0 || sdram_addr !== '0) begin
        n_fail++; $display("FAIL reset_data[%0d]: gfx_data=%h sdram_addr=%h, want 0 0", k, gfx_data, sdram_addr);
      end
      n_chk++;
      if (hits !== 16'h0 || misses !== 16'h0) begin
        n_fail++; $display("FAIL reset_cnt[%0d]: hits=%0d misses=%0d, want 0 0", k, hits, misses);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_cold_miss();
    obs_t o;
    void'(mdl_access(18'h00100, 32'hDEAD_BEEF));
    run_req(18'h00100, 32'hDEAD_BEEF, 5, 1'b0, o);
    n_chk++;
    if (o.cs1 !== 1'b1 || o.cs_addr !== 18'h00100) begin
      n_fail++; $display("FAIL cold_sdram_req: cs1=%b addr=%h, want 1 00100", o.cs1, o.cs_addr);
    end
    n_chk++;
    if (o.ok_cyc !== 8) begin
      n_fail++; $display("FAIL cold_latency: gfx_ok cycle=%0d, want 8", o.ok_cyc);
    end
    n_chk++;
    if (o.data !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL cold_data: got %h want deadbeef", o.data);
    end
    n_chk++;
    if (misses !== 16'd1 || hits !== 16'd0) begin
      n_fail++; $display("FAIL cold_counters: hits=%0d misses=%0d, want 0 1", hits, misses);
    end
  endtask

  task automatic test_hit();
    obs_t o;
    void'(mdl_access(18'h00100, 32'h0));
    run_req(18'h00100, 32'h1111_1111, 3, 1'b0, o);
    n_chk++;
    if (obs_kind(o, 18'h00100) !== K_HIT) begin
      n_fail++; $display("FAIL hit_timing: kind=%0d ok_cyc=%0d cs_seen=%b, want hit", obs_kind(o, 18'h00100), o.ok_cyc, o.cs_seen);
    end
    n_chk++;
    if (o.data !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL hit_data: got %h want deadbeef", o.data);
    end
    n_chk++;
    if (hits !== 16'd1 || misses !== 16'd1) begin
      n_fail++; $display("FAIL hit_counters: hits=%0d misses=%0d, want 1 1", hits, misses);
    end
  endtask

  task automatic test_stale_ok();
    obs_t o;
    logic [AW-1:0] a;
    for (int k = 0; k < 2; k++) begin
      a = 18'h00200 + AW'(k);
      void'(mdl_access(a, sd_word(a)));
      run_req(a, sd_word(a), 1 + 2 * k, 1'b1, o);
      n_chk++;
      if (obs_kind(o, a) !== K_MISS) begin
        n_fail++; $display("FAIL stale_timing[%0d]: kind=%0d ok_cyc=%0d m=%0d, want miss", k, obs_kind(o, a), o.ok_cyc, o.m_cyc);
      end
      n_chk++;
      if (o.data !== sd_word(a)) begin
        n_fail++; $display("FAIL stale_data[%0d]: got %h want %h", k, o.data, sd_word(a));
      end
    end
  endtask

  task automatic pulse_flush_idle();
    gfx_cs = 1'b0;
    flush  = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    mdl_flush();
  endtask

  task automatic test_replacement();
    obs_t o;
    logic [AW-1:0] a;
    pulse_flush_idle();
    for (int k = 0; k < 5; k++) begin
      a = 18'h00010 + AW'(k);
      void'(mdl_access(a, sd_word(a)));
      run_req(a, sd_word(a), 2, 1'b0, o);
      n_chk++;
      if (obs_kind(o, a) !== K_MISS || o.data !== sd_word(a)) begin
        n_fail++; $display("FAIL repl_fill[%0d]: kind=%0d data=%h, want miss %h", k, obs_kind(o, a), o.data, sd_word(a));
      end
    end
    void'(mdl_access(18'h00011, 32'h0));
    run_req(18'h00011, 32'h0, 2, 1'b0, o);
    n_chk++;
    if (obs_kind(o, 18'h00011) !== K_HIT || o.data !== sd_word(18'h00011)) begin
      n_fail++; $display("FAIL repl_keep11: kind=%0d data=%h, want hit %h", obs_kind(o, 18'h00011), o.data, sd_word(18'h00011));
    end
    void'(mdl_access(18'h00010, sd_word(18'h00010)));
    run_req(18'h00010, sd_word(18'h00010), 2, 1'b0, o);
    n_chk++;
    if (obs_kind(o, 18'h00010) !== K_MISS) begin
      n_fail++; $display("FAIL repl_evict10: kind=%0d, want miss", obs_kind(o, 18'h00010));
    end
    n_chk++;
    if (hits !== 16'(mdl_hits) || misses !== 16'(mdl_misses)) begin
      n_fail++; $display("FAIL repl_counters: hits=%0d misses=%0d, want %0d %0d", hits, misses, mdl_hits, mdl_misses);
    end
  endtask

  task automatic test_addr_change();
    obs_t o;
    int age, bad;
    bit second;
    logic [AW-1:0] a0;
    void'(mdl_access(18'h00020, sd_word(18'h00020)));
    gfx_addr = 18'h00020; gfx_cs = 1'b1;
    age = 0; bad = 0; second = 0; a0 = '0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (gfx_ok) bad++;
      if (c == 1) a0 = sdram_cs ? sdram_addr : '1;
      if (sdram_cs && sdram_addr == 18'h00021) begin
        second = 1;
        break;
      end
      if (c == 1) gfx_addr = 18'h00021;
      if (sdram_cs) begin
        age++;
        sdram_ok   = (age == 3);
        sdram_data = (age == 3) ? sd_word(18'h00020) : 32'h0;
      end else begin
        sdram_ok = 1'b0;
      end
    end
    n_chk++;
    if (a0 !== 18'h00020) begin
      n_fail++; $display("FAIL chg_first_fetch: sdram_addr=%h, want 00020", a0);
    end
    n_chk++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL chg_no_ok: gfx_ok seen %0d cycles, want 0", bad);
    end
    n_chk++;
    if (second !== 1'b1) begin
      n_fail++; $display("FAIL chg_refetch: second fetch seen=%b, want 1", second);
    end
    void'(mdl_access(18'h00021, sd_word(18'h00021)));
    run_req(18'h00021, sd_word(18'h00021), 2, 1'b0, o);
    n_chk++;
    if (obs_kind(o, 18'h00021) !== K_MISS || o.data !== sd_word(18'h00021)) begin
      n_fail++; $display("FAIL chg_fetch21: kind=%0d data=%h, want miss %h", obs_kind(o, 18'h00021), o.data, sd_word(18'h00021));
    end
    void'(mdl_access(18'h00020, 32'h0));
    run_req(18'h00020, 32'h0, 2, 1'b0, o);
    n_chk++;
    if (obs_kind(o, 18'h00020) !== K_HIT || o.data !== sd_word(18'h00020)) begin
      n_fail++; $display("FAIL chg_cached20: kind=%0d data=%h, want hit %h", obs_kind(o, 18'h00020), o.data, sd_word(18'h00020));
    end
  endtask

  task automatic test_flush();
    obs_t o;
    int age, bad;
    bit dropped, refetch;
    logic [AW-1:0] ra;
    // Flush while a hit is being returned: gfx_ok drops and the line is gone.
    gfx_addr = 18'h00020; gfx_cs = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if (gfx_ok !== 1'b1) begin
      n_fail++; $display("FAIL flush_pre_hit: gfx_ok=%b, want 1", gfx_ok);
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    mdl_flush();
    n_chk++;
    if (gfx_ok !== 1'b0 || hits !== 16'd0 || misses !== 16'd0) begin
      n_fail++; $display("FAIL flush_clear: gfx_ok=%b hits=%0d misses=%0d, want 0 0 0", gfx_ok, hits, misses);
    end
    void'(mdl_access(18'h00020, sd_word(18'h00020)));
    run_req(18'h00020, sd_word(18'h00020), 2, 1'b0, o);
    n_chk++;
    if (obs_kind(o, 18'h00020) !== K_MISS || o.data !== sd_word(18'h00020)) begin
      n_fail++; $display("FAIL flush_refill20: kind=%0d data=%h, want miss %h", obs_kind(o, 18'h00020), o.data, sd_word(18'h00020));
    end
    // Flush while 0x30 is in WAIT: the returned word must not be cached or shown.
    void'(mdl_access(18'h00030, 32'h0BAD_F00D));
    gfx_addr = 18'h00030; gfx_cs = 1'b1;
    age = 0; bad = 0; dropped = 0; refetch = 0; ra = '0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      flush = 1'b0;
      if (gfx_ok) bad++;
      if (sdram_cs && dropped) begin
        refetch = 1; ra = sdram_addr;
        break;
      end
      if (sdram_cs) begin
        age++;
        if (age == 1) flush = 1'b1;
        sdram_ok   = (age == 3);
        sdram_data = (age == 3) ? 32'h0BAD_F00D : 32'h0;
      end else begin
        sdram_ok = 1'b0;
        if (age > 0) dropped = 1;
      end
    end
    flush = 1'b0;
    mdl_flush();
    n_chk++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL flush_wait_no_ok: gfx_ok seen %0d cycles, want 0", bad);
    end
    n_chk++;
    if (refetch !== 1'b1 || ra !== 18'h00030) begin
      n_fail++; $display("FAIL flush_wait_refetch: seen=%b addr=%h, want 1 00030", refetch, ra);
    end
    void'(mdl_access(18'h00030, 32'h600D_CAFE));
    run_req(18'h00030, 32'h600D_CAFE, 2, 1'b0, o);
    n_chk++;
    if (obs_kind(o, 18'h00030) !== K_MISS || o.data !== 32'h600D_CAFE) begin
      n_fail++; $display("FAIL flush_wait_data: kind=%0d data=%h, want miss 600dcafe", obs_kind(o, 18'h00030), o.data);
    end
    n_chk++;
    if (hits !== 16'd0 || misses !== 16'd1) begin
      n_fail++; $display("FAIL flush_wait_counters: hits=%0d misses=%0d, want 0 1", hits, misses);
    end
  endtask

  task automatic test_random();
    obs_t o;
    logic [AW-1:0] a;
    logic [31:0] exp_d;
    int exp_k, gap;
    for (int it = 0; it < 40; it++) begin
      a = 18'h00040 + AW'($urandom_range(0, 5));
      exp_k = mdl_access(a, sd_word(a)) ? K_HIT : K_MISS;
      exp_d = mdl_data[int'(a)];
      run_req(a, sd_word(a), int'($urandom_range(1, 6)), 1'($urandom_range(0, 1)), o);
      n_chk++;
      if (obs_kind(o, a) !== exp_k) begin
        n_fail++; $display("FAIL rnd_kind[%0d]: addr=%h kind=%0d, want %0d", it, a, obs_kind(o, a), exp_k);
      end
      n_chk++;
      if (o.data !== exp_d) begin
        n_fail++; $display("FAIL rnd_data[%0d]: addr=%h got %h want %h", it, a, o.data, exp_d);
      end
      n_chk++;
      if (hits !== 16'(mdl_hits) || misses !== 16'(mdl_misses)) begin
        n_fail++; $display("FAIL rnd_counters[%0d]: hits=%0d misses=%0d, want %0d %0d", it, hits, misses, mdl_hits, mdl_misses);
      end
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        gfx_addr = 18'h00040 + AW'($urandom_range(0, 5));
        @(posedge clk); #1;
        n_chk++;
        if (gfx_ok !== 1'b0 || sdram_cs !== 1'b0) begin
          n_fail++; $display("FAIL rnd_cs_low[%0d]: gfx_ok=%b sdram_cs=%b, want 0 0", it, gfx_ok, sdram_cs);
        end
      end
    end
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0; flush = 1'b0; gfx_cs = 1'b0; gfx_addr = '0;
    sdram_ok = 1'b0; sdram_data = '0;
    mdl_flush();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_cold_miss();
    test_hit();
    test_stale_ok();
    test_replacement();
    test_addr_change();
    test_flush();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
